// File: rtl/pwm_gen.sv
// Counter-based PWM generator with a one-entry shadow register for duty updates.
// New duty values are applied only at a period boundary, or immediately while disabled.
module pwm_gen #(
    parameter int                   DUTY_BITS  = 19,
    parameter bit                   INVERT     = 1'b0,
    parameter logic [DUTY_BITS-1:0] RESET_DUTY = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DUTY_BITS-1:0] duty,
    input  logic                 duty_valid,
    output logic                 duty_ready,
    output logic [DUTY_BITS-1:0] active_duty,
    output logic                 period_end,
    output logic                 out
);

    localparam logic [DUTY_BITS-1:0] CNT_MAX  = '1;
    localparam logic [DUTY_BITS-1:0] CNT_LAST = CNT_MAX - DUTY_BITS'(1);

    logic [DUTY_BITS-1:0] cnt;
    logic [DUTY_BITS-1:0] pending;
    logic                 pending_full;
    logic                 boundary;
    logic                 take;
    logic                 drain;

    // Handshake: a word transfers on any rising edge where duty_valid && duty_ready.
    // duty_ready depends only on pending_full, so there is no valid->ready path;
    // upstream must hold duty stable while duty_valid is high and duty_ready is low.
    assign duty_ready = !pending_full;
    assign take       = duty_valid && !pending_full;
    assign boundary   = en && (cnt == CNT_MAX);
    // While disabled the shadow drains at once so the sequencer never stalls.
    assign drain      = pending_full && (boundary || !en);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            active_duty  <= RESET_DUTY;
            pending      <= '0;
            pending_full <= 1'b0;
            period_end   <= 1'b0;
            out          <= INVERT;
        end else begin
            cnt        <= en ? cnt + DUTY_BITS'(1) : '0;
            // Registered one clock early so the strobe lines up with cnt == all-ones.
            period_end <= en && (cnt == CNT_LAST);
            out        <= (en && (cnt < active_duty)) ^ INVERT;
            if (drain) begin
                active_duty  <= pending;
                pending_full <= 1'b0;
            end else if (take) begin
                pending      <= duty;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen at DUTY_BITS=4: one normal-polarity and one inverted
// instance share all inputs so both polarities are checked on every vector.
module tb_pwm_gen;

    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DB-1:0] duty;
    logic          duty_valid;

    logic          duty_ready,  duty_ready_i;
    logic [DB-1:0] active_duty, active_duty_i;
    logic          period_end,  period_end_i;
    logic          out,         out_i;

    int vectors = 0;
    int fails   = 0;

    pwm_gen #(.DUTY_BITS(DB), .INVERT(1'b0), .RESET_DUTY(4'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .duty(duty), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .active_duty(active_duty),
        .period_end(period_end), .out(out)
    );

    pwm_gen #(.DUTY_BITS(DB), .INVERT(1'b1), .RESET_DUTY(4'd0)) dut_inv (
        .clk(clk), .rst(rst), .en(en), .duty(duty), .duty_valid(duty_valid),
        .duty_ready(duty_ready_i), .active_duty(active_duty_i),
        .period_end(period_end_i), .out(out_i)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered with cnt==0; offers d, then runs to the boundary that applies it.
    task automatic load_duty(input logic [DB-1:0] d);
        duty       = d;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        chk("load_ready_low", 32'(duty_ready), 32'd0);
        repeat (15) tick();
        chk("load_active", 32'(active_duty), 32'(d));
        chk("load_ready_high", 32'(duty_ready), 32'd1);
    endtask

    // Entered with cnt==0 and active duty d; checks one full 16-clock period.
    task automatic run_period(input int d);
        int highs;
        highs = 0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk("out", 32'(out), ((j - 1) < d) ? 32'd1 : 32'd0);
            chk("out_inv", 32'(out_i), ((j - 1) < d) ? 32'd0 : 32'd1);
            chk("period_end", 32'(period_end), (j == 15) ? 32'd1 : 32'd0);
            if (out) highs++;
        end
        chk("high_count", 32'(highs), 32'(d));
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        duty       = '0;
        duty_valid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_out_inv", 32'(out_i), 32'd1);
        chk("rst_ready", 32'(duty_ready), 32'd1);
        chk("rst_period_end", 32'(period_end), 32'd0);
        chk("rst_active", 32'(active_duty), 32'd0);

        // Duty 0 from reset: out low for 32 cycles, strobes at 15 and 31
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("r_out", 32'(out), 32'd0);
            chk("r_ready", 32'(duty_ready), 32'd1);
            chk("r_period_end", 32'(period_end), ((i % 16) == 15) ? 32'd1 : 32'd0);
        end

        // Duty sweep, including both extremes; duty 4 covers the inverted output
        load_duty(4'd5);  run_period(5);
        load_duty(4'd15); run_period(15);
        load_duty(4'd0);  run_period(0);
        load_duty(4'd4);  run_period(4);

        // Back-pressure: 3 accepted, 9 held until the cycle after the boundary
        duty       = 4'd3;
        duty_valid = 1'b1;
        tick();
        duty = 4'd9;
        chk("bp_ready_low", 32'(duty_ready), 32'd0);
        repeat (14) tick();
        chk("bp_still_low", 32'(duty_ready), 32'd0);
        chk("bp_active_old", 32'(active_duty), 32'd4);
        tick();
        chk("bp_active_3", 32'(active_duty), 32'd3);
        chk("bp_ready_rise", 32'(duty_ready), 32'd1);
        tick();
        duty_valid = 1'b0;
        chk("bp_9_taken", 32'(duty_ready), 32'd0);
        chk("bp_active_still_3", 32'(active_duty), 32'd3);
        repeat (15) tick();
        chk("bp_active_9", 32'(active_duty), 32'd9);

        // Transfer coincident with the boundary lands in the shadow, not active
        repeat (15) tick();
        chk("co_period_end", 32'(period_end), 32'd1);
        duty       = 4'd7;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        chk("co_active_kept", 32'(active_duty), 32'd9);
        chk("co_ready_low", 32'(duty_ready), 32'd0);
        repeat (15) tick();
        chk("co_active_kept2", 32'(active_duty), 32'd9);
        tick();
        chk("co_active_7", 32'(active_duty), 32'd7);

        // Enable gating mid-period while out is high
        repeat (3) tick();
        chk("en_out_high", 32'(out), 32'd1);
        en = 1'b0;
        tick();
        chk("dis_out", 32'(out), 32'd0);
        chk("dis_out_inv", 32'(out_i), 32'd1);
        chk("dis_period_end", 32'(period_end), 32'd0);
        duty       = 4'd2;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        chk("dis_ready_low", 32'(duty_ready), 32'd0);
        tick();
        chk("dis_active_2", 32'(active_duty), 32'd2);
        chk("dis_ready_high", 32'(duty_ready), 32'd1);
        chk("dis_out_still", 32'(out), 32'd0);
        repeat (20) tick();
        chk("dis_no_strobe", 32'(period_end), 32'd0);
        chk("dis_out_long", 32'(out), 32'd0);
        en = 1'b1;
        run_period(2);

        // Reset mid-period aborts and restores reset values
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rst2_active", 32'(active_duty), 32'd0);
        chk("rst2_out", 32'(out), 32'd0);
        chk("rst2_ready", 32'(duty_ready), 32'd1);
        chk("rst2_period_end", 32'(period_end), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
